// File: rtl/arbitro_pkg.sv
// Shared types and constants for the push-button arbiter: FSM encoding,
// command indices and the LED-state command function.
package arbitro_pkg;

    localparam int N_BOTOES = 4;
    localparam int CNT_W    = 20;

    localparam int CMD_INC  = 0;
    localparam int CMD_DEC  = 1;
    localparam int CMD_CLR  = 2;
    localparam int CMD_LOCK = 3;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        APLICA = 2'd1,
        ESPERA = 2'd2
    } estado_fsm_t;

    // Lock toggle and any command issued while locked leave the LED state as is.
    function automatic logic [2:0] executa_cmd(input logic [1:0] cmd,
                                               input logic [2:0] est,
                                               input logic       trav);
        logic [2:0] res;
        res = est;
        if (!trav) begin
            case (cmd)
                2'(CMD_INC): res = est + 3'd1;
                2'(CMD_DEC): res = est - 3'd1;
                2'(CMD_CLR): res = 3'd0;
                default:     res = est;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/arbitro_botoes_if.sv
// Button-press / LED bus between the debounce units, the arbiter and the board.
interface arbitro_botoes_if;
    import arbitro_pkg::*;

    logic [N_BOTOES-1:0] pulso;
    logic [2:0]          estado;
    logic [2:0]          leds;
    logic                travado;
    logic [N_BOTOES-1:0] concessao;
    logic                ocupado;
    logic                perdido;

    modport master (
        output pulso,
        input  estado, leds, travado, concessao, ocupado, perdido
    );

    modport slave (
        input  pulso,
        output estado, leds, travado, concessao, ocupado, perdido
    );

endinterface

// File: rtl/seletor_rr.sv
// Combinational round-robin winner search starting just after the last grant.
module seletor_rr
    import arbitro_pkg::*;
(
    input  logic [N_BOTOES-1:0] pendente,
    input  logic [1:0]          ponteiro,
    output logic [1:0]          vencedor,
    output logic                valido
);

    logic [1:0] idx;

    // Walk from the farthest candidate back to the nearest so the nearest pending index wins.
    always_comb begin
        vencedor = '0;
        idx      = '0;
        valido   = |pendente;
        for (int k = N_BOTOES; k >= 1; k--) begin
            idx = ponteiro + 2'(k);
            if (pendente[idx]) vencedor = idx;
        end
    end

endmodule

// File: rtl/arbitro_botoes.sv
// Round-robin arbiter sharing the 3-bit LED state between four button commands,
// with a hold-off window after every applied command.
module arbitro_botoes
    import arbitro_pkg::*;
#(
    parameter int unsigned HOLDOFF = 50000
) (
    input  logic               clk,
    input  logic               reset,
    arbitro_botoes_if.slave    bus
);

    localparam logic [CNT_W-1:0] HOLDOFF_M1 = CNT_W'(HOLDOFF - 1);

    estado_fsm_t         fsm_q, fsm_n;
    logic [N_BOTOES-1:0] pendente_q, pendente_n;
    logic [N_BOTOES-1:0] concessao_q, concessao_n;
    logic [N_BOTOES-1:0] limpa;
    logic [1:0]          ponteiro_q, ponteiro_n;
    logic [1:0]          indice_q, indice_n;
    logic [CNT_W-1:0]    contador_q, contador_n;
    logic [2:0]          estado_q, estado_n;
    logic [2:0]          leds_q;
    logic                travado_q, travado_n;
    logic                ocupado_q;
    logic                perdido_q, perdido_n;
    logic [1:0]          vencedor;
    logic                valido;

    seletor_rr u_seletor (
        .pendente (pendente_q),
        .ponteiro (ponteiro_q),
        .vencedor (vencedor),
        .valido   (valido)
    );

    always_ff @(posedge clk) begin
        if (reset) fsm_q <= OCIOSO;
        else       fsm_q <= fsm_n;
    end

    always_comb begin
        fsm_n = fsm_q;
        case (fsm_q)
            OCIOSO:  if (valido) fsm_n = APLICA;
            APLICA:  fsm_n = ESPERA;
            ESPERA:  if (contador_q == HOLDOFF_M1) fsm_n = OCIOSO;
            default: fsm_n = OCIOSO;
        endcase
    end

    always_comb begin
        concessao_n = '0;
        limpa       = '0;
        indice_n    = indice_q;
        ponteiro_n  = ponteiro_q;
        contador_n  = contador_q;
        estado_n    = estado_q;
        travado_n   = travado_q;
        case (fsm_q)
            OCIOSO: begin
                if (valido) begin
                    concessao_n = N_BOTOES'(1) << vencedor;
                    indice_n    = vencedor;
                end
            end
            APLICA: begin
                limpa      = concessao_q;
                ponteiro_n = indice_q;
                contador_n = '0;
                estado_n   = executa_cmd(indice_q, estado_q, travado_q);
                if (indice_q == 2'(CMD_LOCK)) travado_n = ~travado_q;
            end
            ESPERA:  contador_n = contador_q + CNT_W'(1);
            default: ;
        endcase
    end

    // A new press on the clearing edge survives; a press on an already pending bit is dropped.
    assign pendente_n = bus.pulso | (pendente_q & ~limpa);
    assign perdido_n  = perdido_q | (|(bus.pulso & pendente_q & ~limpa));

    always_ff @(posedge clk) begin
        if (reset) begin
            pendente_q  <= '0;
            concessao_q <= '0;
            indice_q    <= '0;
            ponteiro_q  <= 2'd3;
            contador_q  <= '0;
            estado_q    <= '0;
            leds_q      <= '0;
            travado_q   <= 1'b0;
            ocupado_q   <= 1'b0;
            perdido_q   <= 1'b0;
        end else begin
            pendente_q  <= pendente_n;
            concessao_q <= concessao_n;
            indice_q    <= indice_n;
            ponteiro_q  <= ponteiro_n;
            contador_q  <= contador_n;
            estado_q    <= estado_n;
            leds_q      <= estado_n;
            travado_q   <= travado_n;
            ocupado_q   <= (fsm_n != OCIOSO);
            perdido_q   <= perdido_n;
        end
    end

    assign bus.estado    = estado_q;
    assign bus.leds      = leds_q;
    assign bus.travado   = travado_q;
    assign bus.concessao = concessao_q;
    assign bus.ocupado   = ocupado_q;
    assign bus.perdido   = perdido_q;

endmodule

// File: tb/tb_arbitro_botoes.sv
// Directed bench for arbitro_botoes with a short hold-off window.
module tb_arbitro_botoes;

    localparam int H = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    arbitro_botoes_if bus ();

    arbitro_botoes #(.HOLDOFF(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.pulso = '0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    // Returns at the negedge after the sampling edge E0.
    task automatic pulse(input logic [3:0] m);
        bus.pulso = m;
        tick(1);
        bus.pulso = '0;
    endtask

    // Pulse and wait until the arbiter is idle again.
    task automatic apply(input logic [3:0] m);
        pulse(m);
        tick(H + 2);
    endtask

    task automatic test_reset;
        pulse(4'b0001);
        tick(1);
        reset = 1'b1;
        tick(1);
        checks++; if (bus.estado !== 3'd0) begin failures++; $display("FAIL rst_estado got=%0d exp=0", bus.estado); end
        checks++; if (bus.leds !== 3'd0) begin failures++; $display("FAIL rst_leds got=%0d exp=0", bus.leds); end
        checks++; if (bus.travado !== 1'b0) begin failures++; $display("FAIL rst_travado got=%0b exp=0", bus.travado); end
        checks++; if (bus.concessao !== 4'b0000) begin failures++; $display("FAIL rst_concessao got=%b exp=0000", bus.concessao); end
        checks++; if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL rst_ocupado got=%0b exp=0", bus.ocupado); end
        checks++; if (bus.perdido !== 1'b0) begin failures++; $display("FAIL rst_perdido got=%0b exp=0", bus.perdido); end
        reset = 1'b0;
        tick(H + 3);
        checks++; if (bus.estado !== 3'd0) begin failures++; $display("FAIL rst_after_estado got=%0d exp=0", bus.estado); end
        checks++; if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL rst_after_ocupado got=%0b exp=0", bus.ocupado); end
    endtask

    task automatic test_single_inc;
        do_reset();
        pulse(4'b0001);
        checks++; if (bus.concessao !== 4'b0000) begin failures++; $display("FAIL inc_e0_concessao got=%b exp=0000", bus.concessao); end
        checks++; if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL inc_e0_ocupado got=%0b exp=0", bus.ocupado); end
        tick(1);
        checks++; if (bus.concessao !== 4'b0001) begin failures++; $display("FAIL inc_e1_concessao got=%b exp=0001", bus.concessao); end
        checks++; if (bus.ocupado !== 1'b1) begin failures++; $display("FAIL inc_e1_ocupado got=%0b exp=1", bus.ocupado); end
        checks++; if (bus.estado !== 3'd0) begin failures++; $display("FAIL inc_e1_estado got=%0d exp=0", bus.estado); end
        tick(1);
        checks++; if (bus.estado !== 3'd1) begin failures++; $display("FAIL inc_e2_estado got=%0d exp=1", bus.estado); end
        checks++; if (bus.leds !== 3'd1) begin failures++; $display("FAIL inc_e2_leds got=%0d exp=1", bus.leds); end
        checks++; if (bus.concessao !== 4'b0000) begin failures++; $display("FAIL inc_e2_concessao got=%b exp=0000", bus.concessao); end
        tick(H - 1);
        checks++; if (bus.ocupado !== 1'b1) begin failures++; $display("FAIL inc_hold_ocupado got=%0b exp=1", bus.ocupado); end
        tick(1);
        checks++; if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL inc_end_ocupado got=%0b exp=0", bus.ocupado); end
        for (int i = 0; i < 6; i++) apply(4'b0001);
        checks++; if (bus.estado !== 3'd7) begin failures++; $display("FAIL inc_seven_estado got=%0d exp=7", bus.estado); end
        apply(4'b0001);
        checks++; if (bus.estado !== 3'd0) begin failures++; $display("FAIL inc_wrap_estado got=%0d exp=0", bus.estado); end
        checks++; if (bus.leds !== 3'd0) begin failures++; $display("FAIL inc_wrap_leds got=%0d exp=0", bus.leds); end
    endtask

    task automatic test_dec_wrap;
        do_reset();
        apply(4'b0010);
        checks++; if (bus.estado !== 3'd7) begin failures++; $display("FAIL dec_wrap_estado got=%0d exp=7", bus.estado); end
        apply(4'b0010);
        checks++; if (bus.estado !== 3'd6) begin failures++; $display("FAIL dec_second_estado got=%0d exp=6", bus.estado); end
    endtask

    task automatic test_simultaneous;
        do_reset();
        for (int i = 0; i < 3; i++) apply(4'b0001);
        // Two lock toggles leave travado clear and the last winner at index 3.
        apply(4'b1000);
        apply(4'b1000);
        checks++; if (bus.estado !== 3'd3) begin failures++; $display("FAIL sim_start_estado got=%0d exp=3", bus.estado); end
        checks++; if (bus.travado !== 1'b0) begin failures++; $display("FAIL sim_start_travado got=%0b exp=0", bus.travado); end
        pulse(4'b0111);
        tick(1);
        checks++; if (bus.concessao !== 4'b0001) begin failures++; $display("FAIL sim_g1_concessao got=%b exp=0001", bus.concessao); end
        tick(1);
        checks++; if (bus.estado !== 3'd4) begin failures++; $display("FAIL sim_g1_estado got=%0d exp=4", bus.estado); end
        tick(H);
        checks++; if (bus.concessao !== 4'b0000) begin failures++; $display("FAIL sim_gap_concessao got=%b exp=0000", bus.concessao); end
        checks++; if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL sim_gap_ocupado got=%0b exp=0", bus.ocupado); end
        tick(1);
        checks++; if (bus.concessao !== 4'b0010) begin failures++; $display("FAIL sim_g2_concessao got=%b exp=0010", bus.concessao); end
        tick(1);
        checks++; if (bus.estado !== 3'd3) begin failures++; $display("FAIL sim_g2_estado got=%0d exp=3", bus.estado); end
        tick(H + 1);
        checks++; if (bus.concessao !== 4'b0100) begin failures++; $display("FAIL sim_g3_concessao got=%b exp=0100", bus.concessao); end
        tick(1);
        checks++; if (bus.estado !== 3'd0) begin failures++; $display("FAIL sim_g3_estado got=%0d exp=0", bus.estado); end
        tick(H);
        checks++; if (bus.perdido !== 1'b0) begin failures++; $display("FAIL sim_perdido got=%0b exp=0", bus.perdido); end
        checks++; if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL sim_idle_ocupado got=%0b exp=0", bus.ocupado); end
    endtask

    task automatic test_lock;
        do_reset();
        apply(4'b0001);
        apply(4'b1000);
        checks++; if (bus.travado !== 1'b1) begin failures++; $display("FAIL lock_on_travado got=%0b exp=1", bus.travado); end
        apply(4'b0001);
        checks++; if (bus.estado !== 3'd1) begin failures++; $display("FAIL lock_inc_estado got=%0d exp=1", bus.estado); end
        apply(4'b0100);
        checks++; if (bus.estado !== 3'd1) begin failures++; $display("FAIL lock_clr_estado got=%0d exp=1", bus.estado); end
        apply(4'b1000);
        checks++; if (bus.travado !== 1'b0) begin failures++; $display("FAIL lock_off_travado got=%0b exp=0", bus.travado); end
        apply(4'b0001);
        checks++; if (bus.estado !== 3'd2) begin failures++; $display("FAIL unlock_inc_estado got=%0d exp=2", bus.estado); end
        apply(4'b0100);
        checks++; if (bus.estado !== 3'd0) begin failures++; $display("FAIL unlock_clr_estado got=%0d exp=0", bus.estado); end
    endtask

    task automatic test_drop_reset;
        logic [3:0] seen;
        do_reset();
        pulse(4'b0001);
        tick(2);
        pulse(4'b0001);
        pulse(4'b0001);
        checks++; if (bus.perdido !== 1'b1) begin failures++; $display("FAIL drop_perdido got=%0b exp=1", bus.perdido); end
        tick(4 + H);
        checks++; if (bus.estado !== 3'd2) begin failures++; $display("FAIL drop_estado got=%0d exp=2", bus.estado); end
        tick(H + 2);
        checks++; if (bus.estado !== 3'd2) begin failures++; $display("FAIL drop_single_estado got=%0d exp=2", bus.estado); end
        checks++; if (bus.perdido !== 1'b1) begin failures++; $display("FAIL drop_sticky got=%0b exp=1", bus.perdido); end
        pulse(4'b0001);
        tick(2);
        pulse(4'b0010);
        reset = 1'b1;
        tick(1);
        checks++; if (bus.estado !== 3'd0) begin failures++; $display("FAIL midrst_estado got=%0d exp=0", bus.estado); end
        checks++; if (bus.leds !== 3'd0) begin failures++; $display("FAIL midrst_leds got=%0d exp=0", bus.leds); end
        checks++; if (bus.ocupado !== 1'b0) begin failures++; $display("FAIL midrst_ocupado got=%0b exp=0", bus.ocupado); end
        checks++; if (bus.perdido !== 1'b0) begin failures++; $display("FAIL midrst_perdido got=%0b exp=0", bus.perdido); end
        checks++; if (bus.travado !== 1'b0) begin failures++; $display("FAIL midrst_travado got=%0b exp=0", bus.travado); end
        checks++; if (bus.concessao !== 4'b0000) begin failures++; $display("FAIL midrst_concessao got=%b exp=0000", bus.concessao); end
        reset = 1'b0;
        seen = '0;
        for (int i = 0; i < H + 6; i++) begin
            tick(1);
            seen = seen | bus.concessao;
        end
        checks++; if (seen !== 4'b0000) begin failures++; $display("FAIL midrst_no_grant got=%b exp=0000", seen); end
        checks++; if (bus.estado !== 3'd0) begin failures++; $display("FAIL midrst_after_estado got=%0d exp=0", bus.estado); end
    endtask

    initial begin
        bus.pulso = '0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        test_reset();
        test_single_inc();
        test_dec_wrap();
        test_simultaneous();
        test_lock();
        test_drop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arbitro_botoes.md
# arbitro_botoes

Round-robin controller that shares the 3-bit LED state register between four debounced push-button press pulses. Each button owns a fixed command: increment, decrement, clear or lock toggle. Presses are latched as pending requests and granted one at a time. Each grant is followed by a hold-off window before the next command is applied. The block sits between the per-button debounce/edge-detect units and the board LEDs.

## Interface
- HOLDOFF, 50000: idle cycles after each applied command (1 ms at 50 MHz); legal range 1 to 2^20-1.
- clk  input  1  system clock (50 MHz typical).
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- pulso  input  4  one-cycle press pulses from the debounce units. Bit 0 = increment, 1 = decrement, 2 = clear, 3 = lock toggle.
- estado  output  3  current state register, S0..S7.
- leds  output  3  copy of estado, registered on the same edge.
- travado  output  1  lock flag; when 1, increment, decrement and clear have no effect.
- concessao  output  4  one-hot grant, high for exactly the APLICA cycle.
- ocupado  output  1  high whenever the FSM is not in OCIOSO.
- perdido  output  1  sticky flag: a press was dropped because its request was already pending. Cleared only by reset.

## Operation
- **Reset values:** estado=0, leds=0, travado=0, concessao=0, ocupado=0, perdido=0, pendente=0, contador=0, FSM=OCIOSO, ponteiro_rr=3 (so index 0 has first priority).
- **Pending latch:** pendente[i] is set on any edge where pulso[i]=1.
  - Cleared on the edge that leaves APLICA when i was granted.
  - If a clear and a new pulso[i] occur on the same edge, the set wins and the new press is kept.
- **Drop:** pulso[i]=1 while pendente[i]=1 and that bit is not being cleared on this edge → perdido<=1. The request count for i stays at one.
- **FSM states:**
  - OCIOSO: if pendente≠0, select winner round-robin, register it in concessao, go to APLICA. Otherwise stay.
  - APLICA: execute the granted command, clear its pendente bit, set ponteiro_rr=winner, contador<=0, concessao<=0, go to ESPERA.
  - ESPERA: contador increments each cycle. When contador==HOLDOFF-1, go to OCIOSO.
- **Round-robin:** search indices ponteiro_rr+1, +2, +3, +4 (mod 4); the first pending index wins.
- **Commands:**
  - Increment: estado+1 mod 8 (7→0).
  - Decrement: estado-1 mod 8 (0→7).
  - Clear: estado<=0.
  - Lock toggle: travado<=~travado; always executes.
  - When travado=1, increment, decrement and clear are still granted and consumed, but estado is unchanged.
- **Outputs:** leds tracks estado every cycle. ocupado is registered from the next FSM state.
- **Reset mid-operation** (any state, any contador value): all registers return to their reset values on that edge. Pending requests are discarded.

## Timing
- Edge E0 samples pulso[i]=1 → pendente[i]=1 after E0.
- Edge E1 (in OCIOSO) → concessao[i]=1 and FSM=APLICA.
- Edge E2 → estado/leds/travado updated, concessao=0, FSM=ESPERA.
- Press-to-LED latency is 2 edges when the FSM is idle.
- ESPERA lasts exactly HOLDOFF cycles. Grants are therefore spaced HOLDOFF+2 cycles apart.
- ocupado is high from E1 through the last ESPERA cycle.
- Pulses arriving during APLICA or ESPERA are latched normally and served in later grants.

## Structure
- Shared package `arbitro_pkg`:
  - State encoding: OCIOSO=2'd0, APLICA=2'd1, ESPERA=2'd2.
  - Command index constants: CMD_INC=0, CMD_DEC=1, CMD_CLR=2, CMD_LOCK=3.
  - N_BOTOES=4.
- Sub-module `seletor_rr`, purely combinational:
  - Inputs: pendente[3:0], ponteiro[1:0].
  - Outputs: vencedor[1:0] and valido.
  - Instantiated once. The FSM, pending latch, hold-off counter (20 bits) and command datapath live in the top module.

## Test plan
- **Single increment.** After reset, pulse bit 0 at cycle 10.
  - Required: concessao=0001 at cycle 11, estado=1 and leds=1 at cycle 12, ocupado low again at cycle 12+HOLDOFF.
  - Eight pulses total → estado wraps back to 0.
- **Decrement wrap.** From reset, pulse bit 1.
  - Required: estado=7. A second decrement gives 6.
- **Simultaneous requests.** Pulses 0, 1 and 2 on the same cycle with estado=3.
  - Required: grants in order 0, 1, 2, spaced HOLDOFF+2 cycles.
  - Required: estado goes 4, 3, 0. perdido stays 0.
- **Lock.** Pulse 3, then 0, then 2.
  - Required: travado=1 and estado unchanged after both commands.
  - Pulse 3 again → travado=0. A following increment gives estado+1.
- **Drop and reset.** Pulse bit 0 twice while its request is still pending during ESPERA.
  - Required: perdido=1 and only one increment applied.
  - Assert reset mid-ESPERA → all outputs return to 0 on the next edge and no pending grant follows.
